mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/mem_access_ctrl_if.sv | 21 ++
 rtl/mem_access_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and memory-stage controller states.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } memstate_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-cache request/response bundle between the memory stage and the dcache.
interface mem_access_ctrl_if;

  logic                   dmemREN;
  logic                   dmemWEN;
  cpu_types_pkg::word_t   dmemaddr;
  cpu_types_pkg::word_t   dmemstore;
  logic                   dhit;
  cpu_types_pkg::word_t   dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues dcache requests, stalls the pipeline
// until dhit, captures load data, and tracks halt, illegal ops and stall cycles.
//
// state | meaning
// IDLE  | no access outstanding; a new op is issued combinationally
// WAIT  | access issued, waiting for dhit; flush is ignored here
// HALT  | halted; no requests until reset
module mem_access_ctrl
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              M_MemRead,
  input  logic              M_MemWrite,
  input  logic              halt_in,
  input  logic              flush,
  input  word_t             alu_output,
  input  word_t             regfile_rdat2,
  mem_access_ctrl_if.master dc,
  output logic              mem_stall,
  output word_t             mem_rdata,
  output logic              halt_out,
  output logic              op_error,
  output logic [15:0]       stall_count
);

  memstate_t state;
  memstate_t next_state;
  logic      op_req;
  logic      req;

  always_comb begin
    op_req = M_MemRead | M_MemWrite;
    req    = 1'b0;
    case (state)
      IDLE:    req = op_req & ~flush;
      WAIT:    req = op_req;
      default: req = 1'b0;
    endcase
    // While reset is held the bus must read idle even if ops are presented.
    req = req & nRST;
  end

  always_comb begin
    dc.dmemREN   = req & M_MemRead;
    dc.dmemWEN   = req & M_MemWrite & ~M_MemRead;
    dc.dmemaddr  = req ? alu_output    : '0;
    dc.dmemstore = req ? regfile_rdat2 : '0;
    mem_stall    = req & ~dc.dhit;
    halt_out     = (state == HALT);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req && !dc.dhit) next_state = WAIT;
        else if (halt_in)    next_state = HALT;
      end
      // Leaving on a dropped op avoids a permanent stall if EX/MEM is cleared.
      WAIT: begin
        if (dc.dhit || !op_req) next_state = halt_in ? HALT : IDLE;
      end
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      mem_rdata   <= '0;
      op_error    <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= next_state;
      if (dc.dmemREN && dc.dhit)
        mem_rdata <= dc.dmemload;
      if (req && M_MemRead && M_MemWrite)
        op_error <= 1'b1;
      if (mem_stall && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule
